serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor built around one full_subtractor cell and a registered borrow. It computes one bit per clock, LSB first.
- Loads two operands on a start handshake.
- Runs WIDTH cycles.
- Presents the full difference and the final borrow with a one-cycle done pulse.
- Serves as the area-cheap multi-bit subtract stage downstream of operand registers and upstream of any result consumer.

---
 rtl/serial_subtractor_pkg.sv | 39 +++
 rtl/full_subtractor.sv | 27 ++
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 tb/tb_serial_subtractor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//
// Purpose:
//   Shared definitions for the bit-serial subtractor slice: the controller
//   state encoding and a constant clog2 helper used to size the bit counter.
//
// Contents:
//   state_e       - IDLE / RUN / DONE controller states (2-bit encoding)
//   DEFAULT_WIDTH - default operand width of the subtractor
//   clog2()       - ceiling log2, usable in parameter/localparam expressions
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

  // Controller states. The encodings are fixed so that waveforms and any
  // downstream debug tooling see the same values across builds.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Ceiling log2. A value of 1 yields 0; callers that need a signal
  // at least one bit wide clamp the result themselves.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned remaining;
    result    = 0;
    remaining = (value > 0) ? value - 1 : 0;
    while (remaining != 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//
// Purpose:
//   One-bit full subtractor cell: computes A - B - Cin for single bits.
//
// Ports:
//   A      in  1  minuend bit
//   B      in  1  subtrahend bit
//   Cin    in  1  incoming borrow
//   Diff   out 1  difference bit  (A ^ B ^ Cin)
//   Borrow out 1  outgoing borrow (set when A < B + Cin)
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Diff,
  output logic Borrow
);

  // A borrow is generated when A=0 and B=1, and an incoming borrow
  // propagates through whenever A and B are equal.
  assign Diff   = A ^ B ^ Cin;
  assign Borrow = (~A & B) | (~(A ^ B) & Cin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Bit-serial WIDTH-bit subtractor. On an accepted start it captures both
//   operands and the initial borrow, then feeds one bit per clock (LSB
//   first) through a single full_subtractor cell with a registered borrow.
//   After WIDTH bit cycles the full difference and final borrow are
//   presented on registered outputs together with a one-cycle done pulse.
//
// Parameters:
//   WIDTH       operand/result width in bits (WIDTH >= 2)
//
// Ports:
//   clk         in   1      clock, all state updates on rising edge
//   rst         in   1      asynchronous active-high reset
//   start       in   1      request, sampled only while idle
//   a           in   WIDTH  minuend, captured on the accepted start edge
//   b           in   WIDTH  subtrahend, captured on the accepted start edge
//   borrow_in   in   1      initial borrow, captured on the accepted start edge
//   busy        out  1      high while bits are being processed
//   done        out  1      one-cycle pulse, diff/borrow_out valid from here
//   diff        out  WIDTH  (a - b - borrow_in) mod 2^WIDTH
//   borrow_out  out  1      unsigned borrow: a < b + borrow_in
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  // It is clamped to one bit so the declaration stays legal for any width.
  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : int'(clog2(WIDTH));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   aSh_q, aSh_d;
  logic [WIDTH-1:0]   bSh_q, bSh_d;
  logic [WIDTH-2:0]   resSh_q, resSh_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrowOut_q, borrowOut_d;

  logic               cellDiff;
  logic               cellBorrow;
  logic [WIDTH-1:0]   resFull;

  // The single arithmetic cell. It always looks at the current LSBs of the
  // operand shift registers and the registered borrow.
  full_subtractor uCell (
    .A      (aSh_q[0]),
    .B      (bSh_q[0]),
    .Cin    (borrow_q),
    .Diff   (cellDiff),
    .Borrow (cellBorrow)
  );

  // The result shift register keeps only the WIDTH-1 bits already produced;
  // the bit coming out of the cell this cycle completes the word. On the
  // last bit cycle this assembled word is exactly the final difference.
  assign resFull = {cellDiff, resSh_q};

  // Next-state and datapath control. Everything holds by default; the
  // idle state only reacts to start, the run state advances one bit per
  // clock, and the done state lasts a single cycle before returning idle.
  // The counter is not advanced on the final bit so it never wraps.
  always_comb begin
    state_d     = state_q;
    aSh_d       = aSh_q;
    bSh_d       = bSh_q;
    resSh_d     = resSh_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    borrowOut_d = borrowOut_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d    = a;
          bSh_d    = b;
          borrow_d = borrow_in;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        aSh_d    = {1'b0, aSh_q[WIDTH-1:1]};
        bSh_d    = {1'b0, bSh_q[WIDTH-1:1]};
        resSh_d  = resFull[WIDTH-1:1];
        borrow_d = cellBorrow;
        if (cnt_q == LAST_CNT) begin
          diff_d      = resFull;
          borrowOut_d = cellBorrow;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register for the controller and datapath. Reset clears every
  // register at once, which also aborts any operation in flight so no done
  // pulse can follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      aSh_q       <= '0;
      bSh_q       <= '0;
      resSh_q     <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aSh_q       <= aSh_d;
      bSh_q       <= bSh_d;
      resSh_q     <= resSh_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      borrowOut_q <= borrowOut_d;
    end
  end

  // Status flags are decoded straight from the state register, so they drop
  // together with the state on an asynchronous reset.
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrowOut_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. An 8-bit instance runs a table
// of vectors plus hand-written sequences for start-hold and mid-run reset;
// a 4-bit instance is swept over every operand/borrow combination. Expected
// results are queued when an operation is started and compared when the
// design raises done.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       bout4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] expDiff;
    logic       expBout;
  } vec_t;

  typedef struct packed {
    logic [7:0] diff;
    logic       bout;
  } exp_t;

  localparam int NUM_VECS = 8;
  vec_t vecs [NUM_VECS];

  exp_t q8 [$];
  exp_t q4 [$];

  int nCompared   = 0;
  int nMismatched = 0;

  // Free-running 100 MHz clock shared by both instances.
  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .borrow_in  (bin8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bout8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .borrow_in  (bin4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (bout4)
  );

  // Single comparison point: every check goes through here so the counts
  // printed in the summary are the ones stepped by the checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pops the oldest expected 8-bit result and compares it with the outputs.
  task automatic scoreCheck8(input string tag);
    exp_t e;
    if (q8.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: done with empty scoreboard", tag);
    end else begin
      e = q8.pop_front();
      checkOutput({tag, " diff"}, 32'(diff8), 32'(e.diff));
      checkOutput({tag, " borrow_out"}, 32'(bout8), 32'(e.bout));
    end
  endtask

  // Drives one start cycle on the 8-bit instance and queues its expected
  // result. After the start edge the operand inputs are scrambled so that a
  // design reading them outside the start edge would be caught.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    a8     = v.a;
    b8     = v.b;
    bin8   = v.bin;
    start8 = 1'b1;
    e.diff = v.expDiff;
    e.bout = v.expBout;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8     = ~v.a;
    b8     = ~v.b;
    bin8   = ~v.bin;
  endtask

  // Called at the sample point right after the start edge. Advances until
  // done (bounded), counting sample points, busy cycles and watching that
  // the registered outputs stay put while the operation runs.
  task automatic waitDone8(output int cycles, output int busyCycles,
                           output int diffStable);
    logic [7:0] heldDiff;
    logic       heldBout;
    heldDiff   = diff8;
    heldBout   = bout8;
    cycles     = 0;
    busyCycles = 0;
    diffStable = 1;
    while (done8 !== 1'b1 && cycles < 40) begin
      if (busy8 === 1'b1) busyCycles++;
      if (diff8 !== heldDiff || bout8 !== heldBout) diffStable = 0;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic waitDone4(output int cycles);
    cycles = 0;
    while (done4 !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Global time bound so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int cyc;
    int busyc;
    int stable;
    int doneCount;
    exp_t e;

    vecs[0] = {8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = {8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = {8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = {8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[4] = {8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[5] = {8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[6] = {8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};
    vecs[7] = {8'hAA, 8'h55, 1'b0, 8'h55, 1'b0};

    // Reset state of both instances.
    #1 rst = 1'b1;
    #12;
    checkOutput("reset busy8", 32'(busy8), 0);
    checkOutput("reset done8", 32'(done8), 0);
    checkOutput("reset diff8", 32'(diff8), 0);
    checkOutput("reset bout8", 32'(bout8), 0);
    checkOutput("reset busy4", 32'(busy4), 0);
    checkOutput("reset diff4", 32'(diff4), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors with latency, busy length and done width checks.
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      waitDone8(cyc, busyc, stable);
      checkOutput($sformatf("vec%0d latency", i), 32'(cyc), 8);
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyc), 8);
      checkOutput($sformatf("vec%0d outputs held in run", i), 32'(stable), 1);
      checkOutput($sformatf("vec%0d busy at done", i), 32'(busy8), 0);
      scoreCheck8($sformatf("vec%0d", i));
      @(negedge clk);
      checkOutput($sformatf("vec%0d done one cycle", i), 32'(done8), 0);
      checkOutput($sformatf("vec%0d idle busy", i), 32'(busy8), 0);
    end

    // Start held high with operands changing during the run: one done for
    // the captured operands, then a second operation only once idle again.
    @(negedge clk);
    a8     = 8'h10;
    b8     = 8'h01;
    bin8   = 1'b0;
    start8 = 1'b1;
    e.diff = 8'h0F;
    e.bout = 1'b0;
    q8.push_back(e);
    @(negedge clk);
    a8 = 8'hFF;
    b8 = 8'h00;
    doneCount = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      if (done8 === 1'b1) doneCount++;
      if (k == 8) scoreCheck8("hold first");
    end
    @(negedge clk);
    checkOutput("hold single done", 32'(doneCount), 1);
    checkOutput("hold back to idle busy", 32'(busy8), 0);
    checkOutput("hold back to idle done", 32'(done8), 0);
    e.diff = 8'hFF;
    e.bout = 1'b0;
    q8.push_back(e);
    @(negedge clk);
    checkOutput("hold second accepted", 32'(busy8), 1);
    start8 = 1'b0;
    waitDone8(cyc, busyc, stable);
    checkOutput("hold second latency", 32'(cyc), 8);
    scoreCheck8("hold second");
    @(negedge clk);

    // Leave a nonzero result with borrow set, then reset in the 4th run cycle.
    applyStimulus(vecs[1]);
    waitDone8(cyc, busyc, stable);
    checkOutput("pre-reset latency", 32'(cyc), 8);
    scoreCheck8("pre-reset");
    @(negedge clk);
    @(negedge clk);
    a8     = 8'h5A;
    b8     = 8'h23;
    bin8   = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre-reset busy", 32'(busy8), 1);
    checkOutput("pre-reset diff held", 32'(diff8), 32'h FF);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset busy", 32'(busy8), 0);
    checkOutput("async reset done", 32'(done8), 0);
    checkOutput("async reset diff", 32'(diff8), 0);
    checkOutput("async reset borrow_out", 32'(bout8), 0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) doneCount++;
    end
    checkOutput("no activity after abort", 32'(doneCount), 0);
    checkOutput("scoreboard empty", 32'(q8.size()), 0);

    // Exhaustive sweep of the 4-bit instance against an arithmetic model.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp_t e4;
          logic [4:0] full;
          full    = 5'(ia) - 5'(ib) - 5'(ic);
          e4.diff = {4'b0, full[3:0]};
          e4.bout = (ia < ib + ic);
          @(negedge clk);
          a4     = 4'(ia);
          b4     = 4'(ib);
          bin4   = 1'(ic);
          start4 = 1'b1;
          q4.push_back(e4);
          @(negedge clk);
          start4 = 1'b0;
          a4     = ~a4;
          b4     = ~b4;
          waitDone4(cyc);
          if (cyc >= 20) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL sweep a=%0d b=%0d bin=%0d: done timeout", ia, ib, ic);
            q4.delete();
          end else begin
            e4 = q4.pop_front();
            checkOutput($sformatf("sweep a=%0d b=%0d bin=%0d diff", ia, ib, ic),
                        32'(diff4), 32'(e4.diff[3:0]));
            checkOutput($sformatf("sweep a=%0d b=%0d bin=%0d borrow_out", ia, ib, ic),
                        32'(bout4), 32'(e4.bout));
          end
          @(negedge clk);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_serial_subtractor
